// File: rtl/l2_req_arbiter_pkg.sv
// Shared types and defaults for the L1-to-L2 request arbiter.
// Package l2_arb_pkg; the perf helper is only used when L2_ARB_PERF_EN is defined.
package l2_arb_pkg;

    localparam int TNUM_DEF = 18;
    localparam int INUM_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        SERVE_I,
        SERVE_D,
        RELEASE,
        FLUSH
    } arb_state_t;

    typedef enum logic {
        CMD_RD,
        CMD_WR
    } cmd_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/l2_req_arbiter_if.sv
// Single L2_controller request port: the arbiter is the master, the L2 controller the slave.
interface l2_req_arbiter_if #(
    parameter int TNUM = 18,
    parameter int INUM = 26 - TNUM
);
    logic            read_L1_L2;
    logic            write_L1_L2;
    logic [TNUM-1:0] tag_L1_L2;
    logic [INUM-1:0] index_L1_L2;
    logic            flush;
    logic            ready_L2_L1;

    modport master (
        output read_L1_L2, write_L1_L2, tag_L1_L2, index_L1_L2, flush,
        input  ready_L2_L1
    );

    modport slave (
        input  read_L1_L2, write_L1_L2, tag_L1_L2, index_L1_L2, flush,
        output ready_L2_L1
    );
endinterface

// File: rtl/l2_req_arbiter_rr_arb2.sv
// Two-way round-robin pick between the I and D requesters, plus the last-grant register.
module rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic req_i,
    input  logic req_d,
    input  logic update,
    output logic gnt_i,
    output logic gnt_d
);
    // Set when D won the most recent grant; reset to I so D wins the first tie.
    logic last_d_q, last_d_d;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        gnt_d    = req_d && (!req_i || !last_d_q);
        gnt_i    = req_i && !gnt_d;
        last_d_d = last_d_q;
        if (update) begin
            last_d_d = gnt_d;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_d_q <= 1'b0;
        end else begin
            last_d_q <= last_d_d;
        end
    end
endmodule

// File: rtl/l2_req_arbiter.sv
// Arbitrates the L1 I/D caches onto one L2 request port and sequences flush pulses.
// Optional macro L2_ARB_PERF_EN adds saturating grant/conflict counters and their ports.
module l2_req_arbiter
    import l2_arb_pkg::*;
#(
    parameter int TNUM = TNUM_DEF,
    parameter int INUM = 26 - TNUM
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            read_I_L2,
    input  logic [TNUM-1:0] tag_I_L2,
    input  logic [INUM-1:0] index_I_L2,
    output logic            ready_L2_I,
    input  logic            read_D_L2,
    input  logic            write_D_L2,
    input  logic [TNUM-1:0] tag_D_L2,
    input  logic [INUM-1:0] index_D_L2,
    output logic            ready_L2_D,
    input  logic            flush_req,
    output logic            grant_D,
    output logic            busy,
    l2_req_arbiter_if.master l2
`ifdef L2_ARB_PERF_EN
    ,
    output logic [31:0]     perf_grant_I,
    output logic [31:0]     perf_grant_D,
    output logic [31:0]     perf_conflict
`endif
);
    arb_state_t      state_q, state_d;
    logic            flush_pend_q, flush_pend_d;
    logic [TNUM-1:0] lat_tag_q, lat_tag_d;
    logic [INUM-1:0] lat_index_q, lat_index_d;
    cmd_t            lat_cmd_q, lat_cmd_d;
    logic            read_q, read_d;
    logic            write_q, write_d;
    logic [TNUM-1:0] tag_q, tag_d;
    logic [INUM-1:0] index_q, index_d;
    logic            flush_q, flush_d;
    logic            grant_d_q, grant_d_d;
    logic            busy_q, busy_d;

    logic req_i, req_d, gnt_i, gnt_d, flush_go, grant_upd, in_serve;

    assign req_i    = read_I_L2;
    assign req_d    = read_D_L2 | write_D_L2;
    assign flush_go = flush_pend_q | flush_req;

    rr_arb2 u_rr (
        .clk    (clk),
        .rst    (rst),
        .req_i  (req_i),
        .req_d  (req_d),
        .update (grant_upd),
        .gnt_i  (gnt_i),
        .gnt_d  (gnt_d)
    );

    always_comb begin
        state_d      = state_q;
        flush_pend_d = flush_pend_q;
        lat_tag_d    = lat_tag_q;
        lat_index_d  = lat_index_q;
        lat_cmd_d    = lat_cmd_q;
        grant_upd    = 1'b0;

        case (state_q)
            IDLE: begin
                if (flush_go) begin
                    state_d = FLUSH;
                end else if (gnt_d) begin
                    state_d     = SERVE_D;
                    grant_upd   = 1'b1;
                    lat_tag_d   = tag_D_L2;
                    lat_index_d = index_D_L2;
                    lat_cmd_d   = write_D_L2 ? CMD_WR : CMD_RD;
                end else if (gnt_i) begin
                    state_d     = SERVE_I;
                    grant_upd   = 1'b1;
                    lat_tag_d   = tag_I_L2;
                    lat_index_d = index_I_L2;
                    lat_cmd_d   = CMD_RD;
                end
            end
            SERVE_I, SERVE_D: begin
                if (l2.ready_L2_L1) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: state_d = IDLE;
            FLUSH: begin
                state_d      = IDLE;
                flush_pend_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        // A flush arriving mid-access waits until the port is back in IDLE.
        if (flush_req && state_q != IDLE && state_q != FLUSH) begin
            flush_pend_d = 1'b1;
        end

        // Outputs are registered from the next state, so they line up with state_q.
        in_serve  = (state_d == SERVE_I) || (state_d == SERVE_D);
        read_d    = in_serve && (lat_cmd_d == CMD_RD);
        write_d   = in_serve && (lat_cmd_d == CMD_WR);
        tag_d     = in_serve ? lat_tag_d : '0;
        index_d   = in_serve ? lat_index_d : '0;
        flush_d   = (state_d == FLUSH);
        grant_d_d = (state_d == SERVE_D);
        busy_d    = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            flush_pend_q <= 1'b0;
            lat_tag_q    <= '0;
            lat_index_q  <= '0;
            lat_cmd_q    <= CMD_RD;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            tag_q        <= '0;
            index_q      <= '0;
            flush_q      <= 1'b0;
            grant_d_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_pend_q <= flush_pend_d;
            lat_tag_q    <= lat_tag_d;
            lat_index_q  <= lat_index_d;
            lat_cmd_q    <= lat_cmd_d;
            read_q       <= read_d;
            write_q      <= write_d;
            tag_q        <= tag_d;
            index_q      <= index_d;
            flush_q      <= flush_d;
            grant_d_q    <= grant_d_d;
            busy_q       <= busy_d;
        end
    end

    assign l2.read_L1_L2  = read_q;
    assign l2.write_L1_L2 = write_q;
    assign l2.tag_L1_L2   = tag_q;
    assign l2.index_L1_L2 = index_q;
    assign l2.flush       = flush_q;
    assign grant_D        = grant_d_q;
    assign busy           = busy_q;
    assign ready_L2_I     = (state_q == SERVE_I) && l2.ready_L2_L1;
    assign ready_L2_D     = (state_q == SERVE_D) && l2.ready_L2_L1;

`ifdef L2_ARB_PERF_EN
    logic [31:0] pg_i_q, pg_i_d, pg_d_q, pg_d_d, pc_q, pc_d;

    always_comb begin
        pg_i_d = pg_i_q;
        pg_d_d = pg_d_q;
        pc_d   = pc_q;
        if (state_q == IDLE && !flush_go && gnt_i) pg_i_d = sat_inc(pg_i_q);
        if (state_q == IDLE && !flush_go && gnt_d) pg_d_d = sat_inc(pg_d_q);
        if (state_q == IDLE && req_i && req_d)     pc_d   = sat_inc(pc_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pg_i_q <= '0;
            pg_d_q <= '0;
            pc_q   <= '0;
        end else begin
            pg_i_q <= pg_i_d;
            pg_d_q <= pg_d_d;
            pc_q   <= pc_d;
        end
    end

    assign perf_grant_I  = pg_i_q;
    assign perf_grant_D  = pg_d_q;
    assign perf_conflict = pc_q;
`endif
endmodule

// File: tb/tb_l2_req_arbiter.sv
// Scoreboard bench for l2_req_arbiter: a behavioural L2 controller checks each access against queued grants.
module tb_l2_req_arbiter;
    import l2_arb_pkg::*;

    localparam int TNUM = TNUM_DEF;
    localparam int INUM = INUM_DEF;

    typedef struct {
        logic            side_d;
        cmd_t            cmd;
        logic [TNUM-1:0] tag;
        logic [INUM-1:0] idx;
    } exp_t;

    typedef enum {P_IDLE, P_WAIT, P_REL} phase_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [TNUM-1:0] tag_I_L2, tag_D_L2;
    logic [INUM-1:0] index_I_L2, index_D_L2;
    logic            read_I_L2, read_D_L2, write_D_L2;
    logic            ready_L2_I, ready_L2_D, flush_req, grant_D, busy;
    logic            l2_rdy, stray_ready, d_rd, d_wr;
    int              i_raise, i_done, d_raise, d_done, done_cnt, l2_lat;
    int              vectors = 0;
    int              miscompares = 0;
    phase_t          phase;
    exp_t            sb[$];
`ifdef L2_ARB_PERF_EN
    logic [31:0]     perf_grant_I, perf_grant_D, perf_conflict;
`endif

    l2_req_arbiter_if #(.TNUM(TNUM), .INUM(INUM)) l2 ();

    // Requests stay high while raised-but-not-completed, so they drop right after their ready pulse.
    assign read_I_L2      = (i_raise != i_done);
    assign read_D_L2      = (d_raise != d_done) && d_rd;
    assign write_D_L2     = (d_raise != d_done) && d_wr;
    assign l2.ready_L2_L1 = l2_rdy | stray_ready;

    l2_req_arbiter #(.TNUM(TNUM), .INUM(INUM)) dut (
        .clk        (clk),
        .rst        (rst),
        .read_I_L2  (read_I_L2),
        .tag_I_L2   (tag_I_L2),
        .index_I_L2 (index_I_L2),
        .ready_L2_I (ready_L2_I),
        .read_D_L2  (read_D_L2),
        .write_D_L2 (write_D_L2),
        .tag_D_L2   (tag_D_L2),
        .index_D_L2 (index_D_L2),
        .ready_L2_D (ready_L2_D),
        .flush_req  (flush_req),
        .grant_D    (grant_D),
        .busy       (busy),
        .l2         (l2)
`ifdef L2_ARB_PERF_EN
        ,
        .perf_grant_I  (perf_grant_I),
        .perf_grant_D  (perf_grant_D),
        .perf_conflict (perf_conflict)
`endif
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic sd, input cmd_t c, input logic [TNUM-1:0] t,
                                input logic [INUM-1:0] x);
        exp_t e;
        e.side_d = sd;
        e.cmd    = c;
        e.tag    = t;
        e.idx    = x;
        return e;
    endfunction

    function automatic logic [TNUM+INUM+6:0] all_outs();
        return {l2.read_L1_L2, l2.write_L1_L2, l2.flush, grant_D, busy, ready_L2_I, ready_L2_D,
                l2.tag_L1_L2, l2.index_L1_L2};
    endfunction

    // Behavioural L2 controller: pops the expected grant when a request appears, answers after l2_lat cycles.
    initial begin : l2_model
        exp_t                 cur;
        int                   wait_left;
        logic [TNUM+INUM+2:0] got_v, want_v;
        phase     = P_IDLE;
        l2_rdy    = 1'b0;
        i_done    = 0;
        d_done    = 0;
        done_cnt  = 0;
        wait_left = 0;
        cur       = mk(1'b0, CMD_RD, '0, '0);
        forever begin
            @(negedge clk);
            if (rst) begin
                l2_rdy = 1'b0;
                phase  = P_IDLE;
                continue;
            end
            case (phase)
                P_IDLE: begin
                    if (l2.read_L1_L2 || l2.write_L1_L2) begin
                        vectors++;
                        if (sb.size() == 0) begin
                            miscompares++;
                            $display("FAIL l2_start: access tag %h seen, no grant expected", l2.tag_L1_L2);
                        end else begin
                            cur    = sb.pop_front();
                            got_v  = {l2.read_L1_L2, l2.write_L1_L2, grant_D, l2.tag_L1_L2, l2.index_L1_L2};
                            want_v = {cur.cmd == CMD_RD, cur.cmd == CMD_WR, cur.side_d, cur.tag, cur.idx};
                            if (got_v !== want_v) begin
                                miscompares++;
                                $display("FAIL l2_start {rd,wr,gntD,tag,idx}: got %h expected %h", got_v, want_v);
                            end
                        end
                        wait_left = l2_lat;
                        phase     = P_WAIT;
                    end
                end
                P_REL: begin
                    l2_rdy = 1'b0;
                    vectors++;
                    if ({l2.read_L1_L2, l2.write_L1_L2, ready_L2_I, ready_L2_D, busy} !== 5'b00001) begin
                        miscompares++;
                        $display("FAIL release {rd,wr,rdyI,rdyD,busy}: got %b expected 00001",
                                 {l2.read_L1_L2, l2.write_L1_L2, ready_L2_I, ready_L2_D, busy});
                    end
                    if (cur.side_d) d_done++;
                    else            i_done++;
                    done_cnt++;
                    phase = P_IDLE;
                end
                default: ;
            endcase
            if (phase == P_WAIT) begin
                if (wait_left == 0) begin
                    l2_rdy = 1'b1;
                    #1;
                    vectors++;
                    got_v  = {ready_L2_I, ready_L2_D, busy, l2.tag_L1_L2, l2.index_L1_L2};
                    want_v = {!cur.side_d, cur.side_d, 1'b1, cur.tag, cur.idx};
                    if (got_v !== want_v) begin
                        miscompares++;
                        $display("FAIL ready {rdyI,rdyD,busy,tag,idx}: got %h expected %h", got_v, want_v);
                    end
                    phase = P_REL;
                end else begin
                    wait_left--;
                end
            end
        end
    end

    task automatic wait_done(input int target);
        int n = 0;
        while (done_cnt < target && n < 300) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (done_cnt < target) begin
            miscompares++;
            $display("FAIL wait_done: completed %0d expected %0d", done_cnt, target);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (all_outs() !== '0) begin
            miscompares++;
            $display("FAIL reset_outs: got %h expected 0", all_outs());
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (all_outs() !== '0) begin
            miscompares++;
            $display("FAIL idle_outs: got %h expected 0", all_outs());
        end
    endtask

    task automatic test_single_read();
        int n = 0;
        int base = done_cnt;
        l2_lat     = 3;
        tag_I_L2   = 18'h2A5C3;
        index_I_L2 = 8'h17;
        sb.push_back(mk(1'b0, CMD_RD, 18'h2A5C3, 8'h17));
        @(negedge clk);
        i_raise++;
        do begin
            @(negedge clk);
            n++;
        end while (!l2.read_L1_L2 && n < 20);
        vectors++;
        if (n != 1 || grant_D !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL grant_latency {cycles,gntD,busy}: got %0d,%b,%b expected 1,0,1", n, grant_D, busy);
        end
        // Requester inputs change after grant; the L2 port must keep the latched values.
        tag_I_L2   = '0;
        index_I_L2 = '1;
        wait_done(base + 1);
    endtask

    task automatic test_tie_alternate();
        l2_lat = 1;
        for (int r = 0; r < 2; r++) begin
            int base = done_cnt;
            tag_D_L2   = 18'h10000 + 18'(r);
            index_D_L2 = 8'hD0 + 8'(r);
            tag_I_L2   = 18'h20000 + 18'(r);
            index_I_L2 = 8'h10 + 8'(r);
            sb.push_back(mk(1'b1, CMD_RD, tag_D_L2, index_D_L2));
            sb.push_back(mk(1'b0, CMD_RD, tag_I_L2, index_I_L2));
            @(negedge clk);
            d_rd = 1'b1;
            d_wr = 1'b0;
            d_raise++;
            i_raise++;
            wait_done(base + 2);
        end
    endtask

    task automatic test_back_to_back();
        int base = done_cnt;
        l2_lat     = 0;
        tag_D_L2   = 18'h3_0001;
        index_D_L2 = 8'h44;
        sb.push_back(mk(1'b1, CMD_RD, 18'h3_0001, 8'h44));
        @(negedge clk);
        d_raise++;
        wait_done(base + 1);
        // D was granted last, so the following tie goes to I.
        tag_I_L2   = 18'h0_0ABC;
        index_I_L2 = 8'h55;
        tag_D_L2   = 18'h3_0002;
        sb.push_back(mk(1'b0, CMD_RD, 18'h0_0ABC, 8'h55));
        sb.push_back(mk(1'b1, CMD_RD, 18'h3_0002, 8'h44));
        @(negedge clk);
        i_raise++;
        d_raise++;
        wait_done(base + 3);
    endtask

    task automatic test_write_priority();
        int base = done_cnt;
        l2_lat     = 2;
        tag_D_L2   = 18'h1_2345;
        index_D_L2 = 8'h80;
        sb.push_back(mk(1'b1, CMD_WR, 18'h1_2345, 8'h80));
        @(negedge clk);
        d_rd = 1'b1;
        d_wr = 1'b1;
        d_raise++;
        wait_done(base + 1);
        d_wr = 1'b0;
    endtask

    task automatic test_flush_pending();
        int n = 0;
        int d_last = -1, flush_k = -1, i_first = -1, flush_hits = 0;
        int base = done_cnt;
        l2_lat     = 3;
        tag_D_L2   = 18'h0_F00D;
        index_D_L2 = 8'h21;
        tag_I_L2   = 18'h0_BEEF;
        index_I_L2 = 8'h22;
        sb.push_back(mk(1'b1, CMD_RD, 18'h0_F00D, 8'h21));
        sb.push_back(mk(1'b0, CMD_RD, 18'h0_BEEF, 8'h22));
        @(negedge clk);
        d_rd = 1'b1;
        d_raise++;
        do begin
            @(negedge clk);
            n++;
        end while (!(l2.read_L1_L2 && grant_D) && n < 20);
        for (int k = 0; k < 40; k++) begin
            if (k > 0) @(negedge clk);
            if (l2.read_L1_L2 && grant_D) d_last = k;
            if (l2.flush) begin
                flush_hits++;
                flush_k = k;
            end
            if (l2.read_L1_L2 && !grant_D && i_first < 0) i_first = k;
            if (k == 0) begin
                flush_req = 1'b1;
                i_raise++;
            end else begin
                flush_req = 1'b0;
            end
        end
        vectors++;
        if (flush_hits != 1 || flush_k != d_last + 3 || i_first != flush_k + 2) begin
            miscompares++;
            $display("FAIL flush_order {hits,flush_at,i_at}: got %0d,%0d,%0d expected 1,%0d,%0d",
                     flush_hits, flush_k, i_first, d_last + 3, d_last + 5);
        end
        wait_done(base + 2);
    endtask

    task automatic test_ignore_ready();
        stray_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vectors++;
            if ({ready_L2_I, ready_L2_D, busy, l2.read_L1_L2} !== 4'b0000) begin
                miscompares++;
                $display("FAIL idle_ready {rdyI,rdyD,busy,rd}: got %b expected 0000",
                         {ready_L2_I, ready_L2_D, busy, l2.read_L1_L2});
            end
        end
        stray_ready = 1'b0;
    endtask

    task automatic test_reset_mid_serve();
        int n = 0;
        int base;
        l2_lat     = 8;
        tag_I_L2   = 18'h1_1111;
        index_I_L2 = 8'h33;
        sb.push_back(mk(1'b0, CMD_RD, 18'h1_1111, 8'h33));
        @(negedge clk);
        i_raise++;
        do begin
            @(negedge clk);
            n++;
        end while (!l2.read_L1_L2 && n < 20);
        @(negedge clk);
        rst = 1'b1;
        #1;
        vectors++;
        if (all_outs() !== '0) begin
            miscompares++;
            $display("FAIL async_reset: got %h expected 0", all_outs());
        end
        i_raise = i_done;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (all_outs() !== '0) begin
            miscompares++;
            $display("FAIL post_reset_idle: got %h expected 0", all_outs());
        end
        base       = done_cnt;
        l2_lat     = 1;
        tag_D_L2   = 18'h2_2222;
        index_D_L2 = 8'h66;
        sb.push_back(mk(1'b1, CMD_RD, 18'h2_2222, 8'h66));
        sb.push_back(mk(1'b0, CMD_RD, 18'h1_1111, 8'h33));
        d_rd = 1'b1;
        d_raise++;
        i_raise++;
        wait_done(base + 2);
    endtask

`ifdef L2_ARB_PERF_EN
    task automatic test_perf();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        l2_lat = 1;
        for (int r = 0; r < 4; r++) begin
            int base = done_cnt;
            tag_D_L2 = 18'h0_0100 + 18'(r);
            tag_I_L2 = 18'h0_0200 + 18'(r);
            sb.push_back(mk(1'b1, CMD_RD, tag_D_L2, index_D_L2));
            sb.push_back(mk(1'b0, CMD_RD, tag_I_L2, index_I_L2));
            @(negedge clk);
            d_raise++;
            i_raise++;
            wait_done(base + 2);
        end
        @(negedge clk);
        vectors++;
        if ({perf_grant_I, perf_grant_D, perf_conflict} !== {32'd4, 32'd4, 32'd4}) begin
            miscompares++;
            $display("FAIL perf {gI,gD,conf}: got %0d,%0d,%0d expected 4,4,4",
                     perf_grant_I, perf_grant_D, perf_conflict);
        end
    endtask
`endif

    initial begin
        rst         = 1'b1;
        flush_req   = 1'b0;
        stray_ready = 1'b0;
        d_rd        = 1'b0;
        d_wr        = 1'b0;
        i_raise     = 0;
        d_raise     = 0;
        l2_lat      = 2;
        tag_I_L2    = '0;
        tag_D_L2    = '0;
        index_I_L2  = '0;
        index_D_L2  = '0;
        test_reset();
        test_single_read();
        test_tie_alternate();
        test_back_to_back();
        test_write_priority();
        test_flush_pending();
        test_ignore_ready();
        test_reset_mid_serve();
`ifdef L2_ARB_PERF_EN
        test_perf();
`endif
        repeat (3) @(negedge clk);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d grants left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
